// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between a master (or interconnect) and the SRAM slave.
interface ahb_sram_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADY;
    logic              HREADYOUT;
    logic              HRESP;
    logic [DATA_W-1:0] HRDATA;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: programmable wait states, two-cycle ERROR response for
// oversized, misaligned or out-of-range transfers, byte-lane write merging.
module ahb_sram_slave #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input logic             HCLK,
    input logic             HRESET,
    ahb_sram_slave_if.slave bus
);
    localparam int NB = DATA_W / 8;
    localparam int BL = $clog2(NB);
    localparam int IW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_ERR1 = 2'd2;
    localparam logic [1:0] S_ERR2 = 2'd3;

    localparam logic [2:0]        WS      = 3'(WAIT_STATES);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    logic [1:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [BL-1:0]     off_q, off_d;
    logic [2:0]        size_q, size_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              slave_rdy;
    logic              accept;
    logic              illegal;
    logic              wr_commit;
    logic              rd_phase;
    logic [2:0]        align_mask;
    logic [ADDR_W-1:0] word_addr;
    logic [NB-1:0]     strb;

    // Address-phase legality: size fits the bus, address aligned, word in range.
    always_comb begin
        case (bus.HSIZE)
            3'd0:    align_mask = 3'b000;
            3'd1:    align_mask = 3'b001;
            3'd2:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
        word_addr = bus.HADDR >> BL;
        illegal   = (bus.HSIZE > 3'(BL))
                 || (|(bus.HADDR[2:0] & align_mask))
                 || (word_addr >= DEPTH_A);
    end

    always_comb begin
        case (state_q)
            S_DATA:  slave_rdy = (cnt_q == 3'd0);
            S_ERR1:  slave_rdy = 1'b0;
            default: slave_rdy = 1'b1;
        endcase
    end

    // Only sample a new address phase in cycles where this slave is not stalling.
    assign accept = bus.HSEL && bus.HTRANS[1] && bus.HREADY && slave_rdy;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        off_d   = off_q;
        size_d  = size_q;
        write_d = write_q;
        case (state_q)
            S_DATA: begin
                if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
                else               state_d = S_IDLE;
            end
            S_ERR1:  state_d = S_ERR2;
            S_ERR2:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            idx_d   = word_addr[IW-1:0];
            off_d   = bus.HADDR[BL-1:0];
            size_d  = bus.HSIZE;
            write_d = bus.HWRITE;
            if (illegal) begin
                state_d = S_ERR1;
                cnt_d   = 3'd0;
            end else begin
                state_d = S_DATA;
                cnt_d   = WS;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            idx_q   <= '0;
            off_q   <= '0;
            size_q  <= 3'd0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            size_q  <= size_d;
            write_q <= write_d;
        end
    end

    // Little-endian lane mask for the registered transfer.
    always_comb begin
        for (int b = 0; b < NB; b++)
            strb[b] = (b >= int'(off_q)) && (b < int'(off_q) + (1 << size_q));
    end

    assign wr_commit = (state_q == S_DATA) && (cnt_q == 3'd0) && write_q && !HRESET;

    // Storage is never reset; reset only blocks a pending commit.
    always_ff @(posedge HCLK) begin
        if (wr_commit) begin
            for (int b = 0; b < NB; b++)
                if (strb[b]) mem_q[idx_q][b*8 +: 8] <= bus.HWDATA[b*8 +: 8];
        end
    end

    // Combinational read sees a write committed on the previous edge.
    assign rd_phase      = (state_q == S_DATA) && !write_q && !HRESET;
    assign bus.HRDATA    = rd_phase ? mem_q[idx_q] : '0;
    assign bus.HREADYOUT = HRESET || slave_rdy;
    assign bus.HRESP     = !HRESET && ((state_q == S_ERR1) || (state_q == S_ERR2));
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench: a zero-wait and a three-wait slave share one pipelined driver.
module tb_ahb_sram_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        which = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd0;
    logic [31:0] hwdata = '0;
    logic        hready, hreadyout, hresp;
    logic [31:0] hrdata;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic        resp;
        int          waits;
        logic        rd;
        logic [31:0] rdata;
        logic        abort;
        int          tag;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    ahb_sram_slave_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
    ahb_sram_slave_if #(.ADDR_W(32), .DATA_W(32)) if1 ();

    assign if0.HSEL   = hsel && !which;
    assign if1.HSEL   = hsel && which;
    assign if0.HADDR  = haddr;   assign if1.HADDR  = haddr;
    assign if0.HTRANS = htrans;  assign if1.HTRANS = htrans;
    assign if0.HWRITE = hwrite;  assign if1.HWRITE = hwrite;
    assign if0.HSIZE  = hsize;   assign if1.HSIZE  = hsize;
    assign if0.HWDATA = hwdata;  assign if1.HWDATA = hwdata;
    assign hready     = which ? if1.HREADYOUT : if0.HREADYOUT;
    assign if0.HREADY = hready;  assign if1.HREADY = hready;
    assign hreadyout  = hready;
    assign hresp      = which ? if1.HRESP  : if0.HRESP;
    assign hrdata     = which ? if1.HRDATA : if0.HRDATA;

    ahb_sram_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_STATES(0)) u_d0 (
        .HCLK(clk), .HRESET(rst), .bus(if0.slave));
    ahb_sram_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_STATES(3)) u_d1 (
        .HCLK(clk), .HRESET(rst), .bus(if1.slave));

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic exp_t e_ok(int tag, int waits, logic rd, logic [31:0] d);
        exp_t e;
        e.resp = 1'b0; e.waits = waits; e.rd = rd; e.rdata = d; e.abort = 1'b0; e.tag = tag;
        return e;
    endfunction

    function automatic exp_t e_err(int tag);
        exp_t e;
        e.resp = 1'b1; e.waits = 1; e.rd = 1'b0; e.rdata = '0; e.abort = 1'b0; e.tag = tag;
        return e;
    endfunction

    // Wait for an edge at which the bus is ready; bounded.
    task automatic wait_rdy_edge(input int tag);
        logic rdy;
        int   n;
        n = 0;
        forever begin
            @(negedge clk); rdy = hready;
            @(posedge clk); #1;
            if (rdy) break;
            n++;
            if (n > 20) begin
                chk($sformatf("t%0d ready timeout", tag), 32'd0, 32'd1);
                break;
            end
        end
    endtask

    // Address phase of one transfer; returns at the start of its data phase.
    task automatic issue(input logic w, input logic [31:0] a, input logic [2:0] s,
                         input logic [31:0] wd, input exp_t e);
        q.push_back(e);
        hsel = 1'b1; htrans = 2'b10; hwrite = w; haddr = a; hsize = s;
        wait_rdy_edge(e.tag);
        hwdata = wd;
    endtask

    task automatic go_idle();
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
        wait_rdy_edge(-1);
    endtask

    // Monitor: pops the expectation whenever a data phase completes.
    initial begin
        bit   dph;
        int   wcnt;
        exp_t e;
        dph = 0; wcnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (dph && q.size() > 0 && q[0].abort) void'(q.pop_front());
                dph = 0;
            end else begin
                if (dph) begin
                    if (q.size() == 0) begin
                        chk("data phase without expectation", 32'd1, 32'd0);
                        dph = 0;
                    end else begin
                        e = q[0];
                        chk($sformatf("t%0d hresp", e.tag), {31'd0, hresp}, {31'd0, e.resp});
                        if (!e.rd) chk($sformatf("t%0d hrdata zero", e.tag), hrdata, 32'd0);
                        if (hreadyout) begin
                            chk($sformatf("t%0d waits", e.tag), 32'(wcnt), 32'(e.waits));
                            if (e.rd) chk($sformatf("t%0d rdata", e.tag), hrdata, e.rdata);
                            void'(q.pop_front());
                            dph = 0;
                        end else begin
                            wcnt++;
                        end
                    end
                end else begin
                    chk("idle hrdata zero", hrdata, 32'd0);
                end
                if (hsel && htrans[1] && hready) begin
                    dph = 1; wcnt = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst d0 hreadyout", {31'd0, if0.HREADYOUT}, 32'd1);
        chk("rst d0 hresp",     {31'd0, if0.HRESP},     32'd0);
        chk("rst d0 hrdata",    if0.HRDATA,             32'd0);
        chk("rst d1 hreadyout", {31'd0, if1.HREADYOUT}, 32'd1);
        chk("rst d1 hresp",     {31'd0, if1.HRESP},     32'd0);
        chk("rst d1 hrdata",    if1.HRDATA,             32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Zero-wait slave: back-to-back write/read, lane merging, errors.
        which = 1'b0;
        issue(1, 32'h10, 3'd2, 32'hDEADBEEF, e_ok(1, 0, 0, 0));
        issue(0, 32'h10, 3'd2, 32'h0,        e_ok(2, 0, 1, 32'hDEADBEEF));
        issue(1, 32'h20, 3'd2, 32'hAAAAAAAA, e_ok(3, 0, 0, 0));
        issue(1, 32'h21, 3'd0, 32'h11111111, e_ok(4, 0, 0, 0));
        issue(1, 32'h23, 3'd0, 32'h22222222, e_ok(5, 0, 0, 0));
        issue(0, 32'h20, 3'd2, 32'h0,        e_ok(6, 0, 1, 32'h22AA11AA));
        issue(1, 32'h22, 3'd1, 32'hBBBBCCCC, e_ok(7, 0, 0, 0));
        issue(0, 32'h21, 3'd0, 32'h0,        e_ok(8, 0, 1, 32'hBBBB11AA));
        issue(1, 32'h00, 3'd2, 32'h01020304, e_ok(9, 0, 0, 0));
        issue(1, 32'h400, 3'd2, 32'h12345678, e_err(10));
        issue(0, 32'h00, 3'd2, 32'h0,        e_ok(11, 0, 1, 32'h01020304));
        issue(0, 32'h400, 3'd2, 32'h0,       e_err(12));
        issue(1, 32'h04, 3'd2, 32'hCAFEF00D, e_ok(13, 0, 0, 0));
        issue(0, 32'h02, 3'd2, 32'h0,        e_err(14));
        issue(0, 32'h04, 3'd2, 32'h0,        e_ok(15, 0, 1, 32'hCAFEF00D));
        issue(1, 32'h06, 3'd2, 32'hFFFFFFFF, e_err(16));
        issue(0, 32'h04, 3'd2, 32'h0,        e_ok(17, 0, 1, 32'hCAFEF00D));
        issue(0, 32'h21, 3'd1, 32'h0,        e_err(18));
        issue(0, 32'h08, 3'd3, 32'h0,        e_err(19));
        issue(0, 32'h20, 3'd2, 32'h0,        e_ok(20, 0, 1, 32'hBBBB11AA));
        go_idle();
        repeat (2) @(posedge clk); #1;

        // Three-wait slave: waited write/read, error timing, reset mid-write.
        which = 1'b1;
        issue(1, 32'h50, 3'd2, 32'h55AA55AA, e_ok(21, 3, 0, 0));
        issue(0, 32'h50, 3'd2, 32'h0,        e_ok(22, 3, 1, 32'h55AA55AA));
        issue(1, 32'h400, 3'd2, 32'h0,       e_err(23));
        go_idle();
        begin
            exp_t ab;
            ab = e_ok(24, 3, 0, 0);
            ab.abort = 1'b1;
            issue(1, 32'h50, 3'd2, 32'h0BADBEEF, ab);
        end
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset hreadyout", {31'd0, hreadyout}, 32'd1);
        chk("post-reset hresp",     {31'd0, hresp},     32'd0);
        @(posedge clk); #1;
        issue(0, 32'h50, 3'd2, 32'h0, e_ok(25, 3, 1, 32'h55AA55AA));
        go_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
